avalon_mem_test_master: RTL

- Avalon-MM master that drives word-addressed on-chip RAM slaves (32-bit data, 4 byte lanes, word address) from the other end of the interface.
- On `start` it performs two passes over a window:
  - writes a deterministic pattern;
  - reads the window back with pipelined reads and compares each returned word.
- Reports pass/fail, error count and first failing address.
- Used as a bring-up/self-test engine beside the soft processor on the system interconnect.

---
 rtl/avalon_mem_test_master_if.sv | 24 ++
 rtl/avalon_mem_test_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_test_master_if.sv
// Avalon-MM bus bundle between the memory test master and a word-addressed RAM slave.
interface avalon_mem_test_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mem_test_master.sv
// Memory self-test engine: writes seed+i over a wrapping window, reads it back with
// pipelined reads and reports pass/fail, mismatch count and first failing address.
//
// state    | meaning
// S_IDLE   | waiting for start; window parameters latched on accept
// S_WRITE  | one write per accepted cycle, address base+i, data seed+i
// S_READ   | issuing reads while outstanding < MAX_OUTSTANDING, comparing returns
// S_DRAIN  | all reads issued, comparing remaining returns
// S_FINISH | done pulse, pass latched, busy released
module avalon_mem_test_master #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       seed,
  input  logic [ADDR_W-1:0]       base,
  input  logic [ADDR_W:0]         length,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_W-1:0]       first_err_addr,
  avalon_mem_test_master_if.master avm
);

  localparam int                OCNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(MAX_OUTSTANDING);
  localparam logic [OCNT_W-1:0] OCNT_ONE = OCNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                read_q, read_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     cmd_cnt_q, cmd_cnt_d;
  logic [ADDR_W:0]     rsp_cnt_q, rsp_cnt_d;
  logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
  logic [DATA_W-1:0]   exp_data_q, exp_data_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;

  logic                cmd_acc;
  logic                rd_acc;
  logic                rsp;
  logic [ADDR_W:0]     cmd_cnt_inc;

  assign cmd_acc     = (write_q || read_q) && !avm.waitrequest;
  assign rd_acc      = read_q && !avm.waitrequest;
  // Returns outside the read phases belong to nobody and are dropped.
  assign rsp         = avm.readdatavalid && (state_q == S_READ || state_q == S_DRAIN);
  assign cmd_cnt_inc = cmd_cnt_q + CNT_ONE;

  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    write_d          = write_q;
    read_d           = read_q;
    len_d            = len_q;
    base_d           = base_q;
    cmd_cnt_d        = cmd_cnt_q;
    rsp_cnt_d        = rsp_cnt_q;
    ocnt_d           = ocnt_q;
    exp_data_d       = exp_data_q;
    exp_addr_d       = exp_addr_q;

    if (rd_acc && !rsp) begin
      ocnt_d = ocnt_q + OCNT_ONE;
    end else if (!rd_acc && rsp) begin
      ocnt_d = ocnt_q - OCNT_ONE;
    end

    if (rsp) begin
      rsp_cnt_d  = rsp_cnt_q + CNT_ONE;
      exp_data_d = exp_data_q + DATA_ONE;
      exp_addr_d = exp_addr_q + ADDR_ONE;
      if (avm.readdata != exp_data_q) begin
        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        if (err_count_q == 16'd0) first_err_addr_d = exp_addr_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        // A start overlapping the done pulse is treated as belonging to the old test.
        if (start && !done_q) begin
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          err_count_d      = 16'd0;
          first_err_addr_d = '0;
          len_d            = length;
          base_d           = base;
          addr_d           = base;
          wdata_d          = seed;
          exp_data_d       = seed;
          exp_addr_d       = base;
          cmd_cnt_d        = '0;
          rsp_cnt_d        = '0;
          ocnt_d           = '0;
          if (length == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_WRITE;
            write_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (cmd_acc) begin
          if (cmd_cnt_inc == len_q) begin
            state_d   = S_READ;
            write_d   = 1'b0;
            read_d    = 1'b1;
            addr_d    = base_q;
            cmd_cnt_d = '0;
          end else begin
            cmd_cnt_d = cmd_cnt_inc;
            addr_d    = addr_q + ADDR_ONE;
            wdata_d   = wdata_q + DATA_ONE;
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          if (cmd_cnt_inc == len_q) begin
            state_d = S_DRAIN;
            read_d  = 1'b0;
          end else begin
            cmd_cnt_d = cmd_cnt_inc;
            addr_d    = addr_q + ADDR_ONE;
            read_d    = (ocnt_d < OCNT_MAX);
          end
        end else if (!read_q) begin
          read_d = (ocnt_d < OCNT_MAX);
        end
      end
      S_DRAIN: begin
        if (rsp_cnt_d == len_q) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count_q == 16'd0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= 16'd0;
      first_err_addr_q <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      write_q          <= 1'b0;
      read_q           <= 1'b0;
      len_q            <= '0;
      base_q           <= '0;
      cmd_cnt_q        <= '0;
      rsp_cnt_q        <= '0;
      ocnt_q           <= '0;
      exp_data_q       <= '0;
      exp_addr_q       <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      write_q          <= write_d;
      read_q           <= read_d;
      len_q            <= len_d;
      base_q           <= base_d;
      cmd_cnt_q        <= cmd_cnt_d;
      rsp_cnt_q        <= rsp_cnt_d;
      ocnt_q           <= ocnt_d;
      exp_data_q       <= exp_data_d;
      exp_addr_q       <= exp_addr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

  assign avm.address    = addr_q;
  assign avm.read       = read_q;
  assign avm.write      = write_q;
  assign avm.writedata  = wdata_q;
  assign avm.byteenable = '1;

endmodule
